// File: rtl/dmem_bus_adapter.sv
// dmem_bus_adapter: turns a core load/store into one word-aligned bus transaction with byte enables,
// stalls the core until it completes, and returns extended load data.
module dmem_bus_adapter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dm_wr_i,
    input  logic        dm_rd_i,
    input  logic [2:0]  dm_ctrl_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_wr_i,
    output logic [31:0] data_rd_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i,
    output logic        misalign_err_o,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, mis_q, mis_d, berr_q, berr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        go, bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign go = dm_wr_i | dm_rd_i;
    assign bad = (dm_ctrl_i[1:0] == 2'b11) || (dm_ctrl_i == 3'b110)
              || (dm_ctrl_i[1:0] == 2'b01 && addr_i[0])
              || (dm_ctrl_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    assign byte_v = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            IDLE: if (go) begin
                if (bad) begin
                    mis_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    we_d    = dm_wr_i;
                    addr_d  = addr_i;
                    ctrl_d  = dm_ctrl_i;
                    be_d    = dm_ctrl_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0]
                            : dm_ctrl_i[1:0] == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                    wdata_d = dm_ctrl_i[1:0] == 2'b00 ? {4{data_wr_i[7:0]}}
                            : dm_ctrl_i[1:0] == 2'b01 ? {2{data_wr_i[15:0]}} : data_wr_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ready_i) begin
                    rdata_d = bus_rdata_i;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // abort with zero data so the core never waits on a hung bus
                    rdata_d = '0;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o        = (state_q == REQ) || (state_q == IDLE && go);
    assign bus_req_o      = req_q;
    assign bus_we_o       = we_q;
    assign bus_addr_o     = {addr_q[31:2], 2'b00};
    assign bus_be_o       = be_q;
    assign bus_wdata_o    = wdata_q;
    assign misalign_err_o = mis_q;
    assign bus_err_o      = berr_q;
    assign data_rd_o = state_q != RESP ? 32'h0
                     : ctrl_q[1:0] == 2'b00 ? {{24{~ctrl_q[2] & byte_v[7]}}, byte_v}
                     : ctrl_q[1:0] == 2'b01 ? {{16{~ctrl_q[2] & half_v[15]}}, half_v}
                     : rdata_q;
endmodule

// File: tb/tb_dmem_bus_adapter.sv
// tb_dmem_bus_adapter: drives core memory ops against a small bus/memory model
// and compares bus activity and returned load data against expectations.
module tb_dmem_bus_adapter;
    logic        clk = 1'b0, rst_n = 1'b0, dm_wr = 1'b0, dm_rd = 1'b0, bus_ready = 1'b0;
    logic [2:0]  dm_ctrl = 3'b000;
    logic [31:0] addr = '0, data_wr = '0, bus_rdata = '0;
    logic [31:0] data_rd, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall, bus_req, bus_we, misalign_err, bus_err;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          o_stall, o_req;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rd, exp_v;
    logic        o_we, o_mis, o_berr, o_done, o_leak;

    dmem_bus_adapter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dm_wr_i(dm_wr), .dm_rd_i(dm_rd), .dm_ctrl_i(dm_ctrl),
        .addr_i(addr), .data_wr_i(data_wr), .data_rd_o(data_rd), .stall_o(stall),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
        .bus_wdata_o(bus_wdata), .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata),
        .misalign_err_o(misalign_err), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One core access; the bus answers after `waits` REQ cycles and updates the memory model.
    task automatic run_op(input logic wr, input logic rd, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d, input int waits);
        int w = 0;
        logic [31:0] cur;
        @(negedge clk);
        dm_wr = wr; dm_rd = rd; dm_ctrl = c; addr = a; data_wr = d;
        o_stall = 0; o_req = 0; o_mis = 0; o_berr = 0; o_done = 0; o_leak = 0;
        o_rd = 'x; o_be = 'x; o_addr = 'x; o_wdata = 'x; o_we = 1'bx;
        for (int cyc = 0; cyc < 40 && !o_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            bus_ready = bus_req && (w == waits);
            bus_rdata = bus_ready ? (mem.exists(bus_addr) ? mem[bus_addr] : 32'h0) : $urandom;
            if (bus_ready && bus_we) begin
                cur = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
                for (int i = 0; i < 4; i++) if (bus_be[i]) cur[8*i +: 8] = bus_wdata[8*i +: 8];
                mem[bus_addr] = cur;
            end
            if (bus_req) begin
                o_req++; w++;
                o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata; o_we = bus_we;
            end
            if (misalign_err) o_mis = 1'b1;
            if (bus_err) o_berr = 1'b1;
            if (stall) begin
                o_stall++;
                if (data_rd !== 32'h0) o_leak = 1'b1;
            end else begin
                o_rd = data_rd; o_done = 1'b1; dm_wr = 1'b0; dm_rd = 1'b0;
            end
        end
        bus_ready = 1'b0;
        checks++;
        if (!o_done) begin errors++; $display("FAIL op_complete: stall never released addr=%h", a); end
    endtask

    task automatic pop_load(input string name);
        exp_v = exp_q.pop_front();
        checks++;
        if (o_rd !== exp_v) begin errors++; $display("FAIL %s data_rd got %h exp %h", name, o_rd, exp_v); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({bus_req, stall, misalign_err, bus_err, bus_we, bus_be, bus_addr, bus_wdata, data_rd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b stall=%b be=%h addr=%h wd=%h rd=%h exp all zero",
                     bus_req, stall, bus_be, bus_addr, bus_wdata, data_rd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0);
        checks++;
        if ({o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
            errors++; $display("FAIL sw_bus got we=%b be=%b addr=%h wd=%h exp 1 1111 100 deadbeef", o_we, o_be, o_addr, o_wdata);
        end
        checks++;
        if (o_stall !== 2) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 2", o_stall); end
        checks++;
        if (o_req !== 1) begin errors++; $display("FAIL sw_req_cycles got %0d exp 1", o_req); end
    endtask

    task automatic test_load_byte();
        mem[32'h100] = 32'h80FF_0000;
        exp_q.push_back(32'hFFFFFF80);
        run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 1);
        checks++;
        if ({o_we, o_be, o_addr} !== {1'b0, 4'b1000, 32'h100}) begin
            errors++; $display("FAIL lb_bus got we=%b be=%b addr=%h exp 0 1000 100", o_we, o_be, o_addr);
        end
        checks++;
        if (o_stall !== 3) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 3", o_stall); end
        pop_load("lb");
        exp_q.push_back(32'h00000080);
        run_op(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 0);
        pop_load("lbu");
        checks++;
        if (o_leak !== 1'b0) begin errors++; $display("FAIL data_rd_outside_resp got nonzero exp zero"); end
    endtask

    task automatic test_half();
        mem.delete(32'h200);
        run_op(1'b1, 1'b0, 3'b001, 32'h202, 32'h0000_1234, 0);
        checks++;
        if ({o_be, o_addr, o_wdata} !== {4'b1100, 32'h200, 32'h12341234}) begin
            errors++; $display("FAIL sh_bus got be=%b addr=%h wd=%h exp 1100 200 12341234", o_be, o_addr, o_wdata);
        end
        run_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0000_009A, 0);
        checks++;
        if ({o_be, o_wdata} !== {4'b1000, 32'h9A9A9A9A}) begin
            errors++; $display("FAIL sb_bus got be=%b wd=%h exp 1000 9a9a9a9a", o_be, o_wdata);
        end
        exp_q.push_back(32'hFFFF9A34);
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 0);
        checks++;
        if (o_be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", o_be); end
        pop_load("lh");
        exp_q.push_back(32'h00009A34);
        run_op(1'b0, 1'b1, 3'b101, 32'h202, 32'h0, 2);
        pop_load("lhu");
        exp_q.push_back(32'h00000034);
        run_op(1'b0, 1'b1, 3'b000, 32'h202, 32'h0, 0);
        pop_load("lb_lane2");
        exp_q.push_back(32'h0);
        run_op(1'b0, 1'b1, 3'b001, 32'h201, 32'h0, 0);
        checks++;
        if ({o_mis, o_berr, o_req, o_stall} !== {1'b1, 1'b0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL lh_misalign got mis=%b berr=%b req=%0d stall=%0d exp 1 0 0 1", o_mis, o_berr, o_req, o_stall);
        end
        pop_load("lh_misalign");
        exp_q.push_back(32'h0);
        run_op(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0);
        checks++;
        if ({o_mis, o_req} !== {1'b1, 32'd0}) begin errors++; $display("FAIL lw_misalign got mis=%b req=%0d exp 1 0", o_mis, o_req); end
        pop_load("lw_misalign");
        exp_q.push_back(32'h0);
        run_op(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 0);
        checks++;
        if ({o_mis, o_req} !== {1'b1, 32'd0}) begin errors++; $display("FAIL illegal_ctrl got mis=%b req=%0d exp 1 0", o_mis, o_req); end
        pop_load("illegal_ctrl");
    endtask

    task automatic test_timeout();
        mem[32'h300] = 32'h5555AAAA;
        exp_q.push_back(32'h0);
        run_op(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 1000);
        checks++;
        if (o_req !== 4) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 4", o_req); end
        checks++;
        if ({o_berr, o_mis} !== 2'b10) begin errors++; $display("FAIL timeout_flags got berr=%b mis=%b exp 1 0", o_berr, o_mis); end
        checks++;
        if (o_stall !== 5) begin errors++; $display("FAIL timeout_stall_cycles got %0d exp 5", o_stall); end
        pop_load("timeout");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dm_rd = 1'b1; dm_ctrl = 3'b010; addr = 32'h500;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, stall} !== 2'b11) begin errors++; $display("FAIL mid_pre_reset got req=%b stall=%b exp 1 1", bus_req, stall); end
        #2;
        rst_n = 1'b0; dm_rd = 1'b0;
        #1;
        checks++;
        if ({bus_req, stall, bus_err, data_rd} !== '0) begin
            errors++; $display("FAIL mid_reset_drop got req=%b stall=%b berr=%b rd=%h exp all zero", bus_req, stall, bus_err, data_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0BADF00D, 1);
        checks++;
        if ({o_req, o_stall, o_we, o_addr} !== {32'd2, 32'd3, 1'b1, 32'h500}) begin
            errors++; $display("FAIL post_reset_sw got req=%0d stall=%0d we=%b addr=%h exp 2 3 1 500", o_req, o_stall, o_we, o_addr);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'hCAFEF00D, 0);
        checks++;
        if ({o_req, o_we} !== {32'd1, 1'b1}) begin errors++; $display("FAIL b2b_sw got req=%0d we=%b exp 1 1", o_req, o_we); end
        exp_q.push_back(32'hCAFEF00D);
        run_op(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 0);
        checks++;
        if ({o_req, o_we, o_stall} !== {32'd1, 1'b0, 32'd2}) begin
            errors++; $display("FAIL b2b_lw got req=%0d we=%b stall=%0d exp 1 0 2", o_req, o_we, o_stall);
        end
        pop_load("b2b_lw");
        run_op(1'b1, 1'b1, 3'b010, 32'h404, 32'h11223344, 0);
        checks++;
        if (o_we !== 1'b1) begin errors++; $display("FAIL store_priority got we=%b exp 1", o_we); end
        exp_q.push_back(32'h11223344);
        run_op(1'b0, 1'b1, 3'b010, 32'h404, 32'h0, 0);
        pop_load("store_priority_lw");
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
